// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_write_arbiter
// Purpose  : Round-robin arbiter sharing the single register-file write port
//            between the pipeline writeback stage (port A) and the
//            multi-cycle execution unit (port B). Holds a pending-write
//            scoreboard that decode uses to stall on outstanding writes.
// Options  : RF_ZERO_LOCK_EN - register 0 is hardwired: granted writes to
//            it are handshaken but never issued; reserves of it are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module rf_write_arbiter #(
  parameter int NREGS = 16,
  parameter int DW    = 16,
  localparam int IW   = $clog2(NREGS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             a_req_i,
  input  logic [IW-1:0]    a_reg_i,
  input  logic [DW-1:0]    a_data_i,
  output logic             a_gnt_o,
  input  logic             b_req_i,
  input  logic [IW-1:0]    b_reg_i,
  input  logic [DW-1:0]    b_data_i,
  output logic             b_gnt_o,
  input  logic             rsv_valid_i,
  input  logic [IW-1:0]    rsv_reg_i,
  output logic             RegWrite_o,
  output logic [IW-1:0]    write_register_o,
  output logic [DW-1:0]    write_data_o,
  output logic [NREGS-1:0] pending_o,
  output logic             rsv_err_o
);

  localparam logic [NREGS-1:0] ONE_HOT0 = {{(NREGS-1){1'b0}}, 1'b1};

  logic             prio_q, prio_d;
  logic             regwrite_q, regwrite_d;
  logic [IW-1:0]    wreg_q, wreg_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [NREGS-1:0] pending_q, pending_d;
  logic             rsv_err_q, rsv_err_d;

  logic             gnt_any;
  logic [IW-1:0]    gnt_reg;
  logic [DW-1:0]    gnt_data;
  logic             issue;
  logic             rsv_eff;
  logic [NREGS-1:0] clr_vec;
  logic [NREGS-1:0] set_vec;
  logic             same_reg_clear;

  // Grant selection, write issue and scoreboard next-state.
  always_comb begin
    // prio=0 favours A, prio=1 favours B; only matters when both request.
    a_gnt_o  = a_req_i & (~b_req_i | ~prio_q);
    b_gnt_o  = b_req_i & (~a_req_i | prio_q);
    gnt_any  = a_gnt_o | b_gnt_o;
    gnt_reg  = b_gnt_o ? b_reg_i  : a_reg_i;
    gnt_data = b_gnt_o ? b_data_i : a_data_i;

    // After a contended grant prio points at the loser: A won -> 1, B won -> 0.
    prio_d = (a_req_i & b_req_i) ? a_gnt_o : prio_q;

`ifdef RF_ZERO_LOCK_EN
    // Register 0 is constant: still handshake, but never write or reserve it.
    issue   = gnt_any & (gnt_reg != '0);
    rsv_eff = rsv_valid_i & (rsv_reg_i != '0);
`else
    issue   = gnt_any;
    rsv_eff = rsv_valid_i;
`endif

    regwrite_d = issue;
    wreg_d     = gnt_any ? gnt_reg  : wreg_q;
    wdata_d    = gnt_any ? gnt_data : wdata_q;

    // Set is OR-ed in after the clear so a same-cycle reserve keeps the bit.
    clr_vec   = gnt_any ? (ONE_HOT0 << gnt_reg)   : '0;
    set_vec   = rsv_eff ? (ONE_HOT0 << rsv_reg_i) : '0;
    pending_d = (pending_q & ~clr_vec) | set_vec;

    // A reserve racing the completing write of the same register is not a
    // double reservation: the old write retires on this very edge.
    same_reg_clear = gnt_any & (gnt_reg == rsv_reg_i);
    rsv_err_d      = rsv_err_q |
                     (rsv_eff & pending_q[rsv_reg_i] & ~same_reg_clear);
  end

  // State registers; reset drops any in-flight write immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q     <= 1'b0;
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
      pending_q  <= '0;
      rsv_err_q  <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      regwrite_q <= regwrite_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
      pending_q  <= pending_d;
      rsv_err_q  <= rsv_err_d;
    end
  end

  assign RegWrite_o       = regwrite_q;
  assign write_register_o = wreg_q;
  assign write_data_o     = wdata_q;
  assign pending_o        = pending_q;
  assign rsv_err_o        = rsv_err_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_write_arbiter
// Purpose  : Directed-vector self-checking bench for rf_write_arbiter.
//            Expected values are hand-computed; RF_ZERO_LOCK_EN selects the
//            register-0 expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;

  localparam int NREGS = 16;
  localparam int DW    = 16;

  logic             clk;
  logic             rst_n;
  logic             a_req, b_req, rsv_valid;
  logic [3:0]       a_reg, b_reg, rsv_reg;
  logic [DW-1:0]    a_data, b_data;
  logic             a_gnt, b_gnt;
  logic             reg_write;
  logic [3:0]       wr_reg;
  logic [DW-1:0]    wr_data;
  logic [NREGS-1:0] pending;
  logic             rsv_err;

  int n_vec  = 0;
  int n_fail = 0;

  rf_write_arbiter #(.NREGS(NREGS), .DW(DW)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .a_req_i          (a_req),
    .a_reg_i          (a_reg),
    .a_data_i         (a_data),
    .a_gnt_o          (a_gnt),
    .b_req_i          (b_req),
    .b_reg_i          (b_reg),
    .b_data_i         (b_data),
    .b_gnt_o          (b_gnt),
    .rsv_valid_i      (rsv_valid),
    .rsv_reg_i        (rsv_reg),
    .RegWrite_o       (reg_write),
    .write_register_o (wr_reg),
    .write_data_o     (wr_data),
    .pending_o        (pending),
    .rsv_err_o        (rsv_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0; a_req = 0; b_req = 0; rsv_valid = 0;
    a_reg = 0; b_reg = 0; rsv_reg = 0; a_data = 0; b_data = 0;
    tick(); tick();
    check("rst_regwrite", {31'b0, reg_write}, 0);
    check("rst_wreg",     {28'b0, wr_reg},    0);
    check("rst_wdata",    {16'b0, wr_data},   0);
    check("rst_pending",  {16'b0, pending},   0);
    check("rst_err",      {31'b0, rsv_err},   0);
    check("rst_gnts",     {30'b0, a_gnt, b_gnt}, 0);
    rst_n = 1'b1;
    tick();

    // Single write from A.
    a_req = 1; a_reg = 3; a_data = 16'h00AA; settle();
    check("t1_gnt", {30'b0, a_gnt, b_gnt}, 32'h2);
    tick(); a_req = 0;
    check("t1_regwrite", {31'b0, reg_write}, 1);
    check("t1_wreg",     {28'b0, wr_reg},    3);
    check("t1_wdata",    {16'b0, wr_data},   32'h00AA);
    tick();
    check("t1_regwrite_off", {31'b0, reg_write}, 0);
    check("t1_wreg_hold",    {28'b0, wr_reg},    3);

    // Contention: A,B,A,B.
    a_req = 1; a_reg = 1; a_data = 16'hA001;
    b_req = 1; b_reg = 5; b_data = 16'hB005; settle();
    check("t2_gnt0", {30'b0, a_gnt, b_gnt}, 32'h2);
    tick(); a_reg = 2; a_data = 16'hA002; settle();
    check("t2_wr0",   {28'b0, wr_reg}, 1);
    check("t2_gnt1", {30'b0, a_gnt, b_gnt}, 32'h1);
    tick(); b_reg = 6; b_data = 16'hB006; settle();
    check("t2_wr1",   {28'b0, wr_reg}, 5);
    check("t2_wd1",   {16'b0, wr_data}, 32'hB005);
    check("t2_gnt2", {30'b0, a_gnt, b_gnt}, 32'h2);
    tick(); a_reg = 3; a_data = 16'hA003; settle();
    check("t2_wr2",   {28'b0, wr_reg}, 2);
    check("t2_gnt3", {30'b0, a_gnt, b_gnt}, 32'h1);
    tick(); b_req = 0; settle();
    check("t2_wr3",   {28'b0, wr_reg}, 6);
    check("t2_rw3",   {31'b0, reg_write}, 1);
    check("t2_gnt4", {30'b0, a_gnt, b_gnt}, 32'h2);
    tick(); a_req = 0;
    check("t2_wr4",   {28'b0, wr_reg}, 3);

    // Reserve 7, then B retires it.
    rsv_valid = 1; rsv_reg = 7;
    tick(); rsv_valid = 0;
    check("t3_pend_set", {16'b0, pending}, 32'h0080);
    b_req = 1; b_reg = 7; b_data = 16'h0777; settle();
    check("t3_bgnt", {30'b0, a_gnt, b_gnt}, 32'h1);
    tick(); b_req = 0;
    check("t3_pend_clr", {16'b0, pending}, 32'h0000);
    check("t3_wd",       {16'b0, wr_data}, 32'h0777);

    // Same-cycle reserve and retire of register 9: set wins, no error.
    rsv_valid = 1; rsv_reg = 9;
    tick();
    check("t4_pend9", {16'b0, pending}, 32'h0200);
    a_req = 1; a_reg = 9; a_data = 16'h0999;
    tick(); rsv_valid = 0;
    check("t4_pend9_keep", {16'b0, pending}, 32'h0200);
    check("t4_err_clean",  {31'b0, rsv_err}, 0);
    tick(); a_req = 0;
    check("t4_pend9_clr", {16'b0, pending}, 32'h0000);

    // Double reserve of register 4 sets the sticky error.
    rsv_valid = 1; rsv_reg = 4;
    tick();
    check("t5_pend4", {16'b0, pending}, 32'h0010);
    check("t5_err0",  {31'b0, rsv_err}, 0);
    tick(); rsv_valid = 0;
    check("t5_err1",  {31'b0, rsv_err}, 1);
    tick();
    check("t5_err_sticky", {31'b0, rsv_err}, 1);
    check("t5_pend4_keep", {16'b0, pending}, 32'h0010);

    // Register 0 handling.
    a_req = 1; a_reg = 0; a_data = 16'h005A; settle();
    check("t6_gnt", {30'b0, a_gnt, b_gnt}, 32'h2);
    tick(); a_req = 0;
`ifdef RF_ZERO_LOCK_EN
    check("t6_rw_zero", {31'b0, reg_write}, 0);
`else
    check("t6_rw_zero", {31'b0, reg_write}, 1);
    check("t6_wr_zero", {28'b0, wr_reg},    0);
`endif
    rsv_valid = 1; rsv_reg = 0;
    tick(); rsv_valid = 0;
`ifdef RF_ZERO_LOCK_EN
    check("t6_pend0", {16'b0, pending}, 32'h0010);
`else
    check("t6_pend0", {16'b0, pending}, 32'h0011);
`endif

    // Async reset while a write is in flight and prio=1.
    a_req = 1; a_reg = 10; a_data = 16'h0A0A;
    b_req = 1; b_reg = 11; b_data = 16'h0B0B; settle();
    check("t7_gnt_a", {30'b0, a_gnt, b_gnt}, 32'h2);
    tick();
    check("t7_rw_on", {31'b0, reg_write}, 1);
    check("t7_gnt_b", {30'b0, a_gnt, b_gnt}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("t7_rw_async",   {31'b0, reg_write}, 0);
    check("t7_pend_async", {16'b0, pending},   0);
    check("t7_err_async",  {31'b0, rsv_err},   0);
    check("t7_wr_async",   {28'b0, wr_reg},    0);
    check("t7_prio_async", {30'b0, a_gnt, b_gnt}, 32'h2);
    a_req = 0; b_req = 0;
    tick(); rst_n = 1'b1;
    tick();
    check("t7_rw_after", {31'b0, reg_write}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the single register-file write port between two writeback requesters: the in-order pipeline writeback stage (port A) and the multi-cycle execution unit (port B). Arbitration is round-robin. The winning write is registered onto the register file's RegWrite / write_register / write_data inputs. A 16-entry pending-write scoreboard lets decode stall on registers whose writes are still outstanding. The block sits between the writeback sources and the register file, alongside the hazard/stall logic.

## Interface
- NREGS, 16, register count; sets scoreboard width and index width log2(NREGS)=4
- DW, 16, write data width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset; asserted low clears all state immediately
- a_req  in  1  port A write request
- a_reg  in  4  port A destination register
- a_data  in  DW  port A write data
- a_gnt  out  1  port A granted this cycle (combinational)
- b_req  in  1  port B write request
- b_reg  in  4  port B destination register
- b_data  in  DW  port B write data
- b_gnt  out  1  port B granted this cycle (combinational)
- rsv_valid  in  1  decode reserves a destination register
- rsv_reg  in  4  register being reserved
- RegWrite  out  1  register-file write enable (registered)
- write_register  out  4  register-file write index (registered)
- write_data  out  DW  register-file write data (registered)
- pending  out  NREGS  scoreboard; bit i set means a write to register i is outstanding
- rsv_err  out  1  sticky flag: a reserve hit an already-pending register

## Operation
- Request handshake: a requester holds req, reg and data stable until it samples gnt=1 at a rising edge. The transfer completes on that edge. At most one grant per cycle.
- Arbitration:
  - Only one requester active: it is granted.
  - Both active: the side selected by the priority flop `prio` wins (0 = A, 1 = B).
  - After a contended grant, `prio` points to the loser. Uncontended grants leave `prio` unchanged.
- Write issue: on a granted edge, RegWrite<=1, write_register<=granted reg, write_data<=granted data. With no grant, RegWrite<=0 and write_register/write_data hold their values.
- Scoreboard:
  - Granted write to register r clears pending[r] on the grant edge.
  - rsv_valid sets pending[rsv_reg] on the same edge.
  - Reserve and clear of the same register in one cycle: set wins, so the bit stays 1.
- rsv_err: set when rsv_valid=1 and pending[rsv_reg]=1 before the edge, excluding a same-cycle clear of that register. It clears only on reset.
- A grant to a non-pending register is legal. The write is issued and the scoreboard is unchanged.

## Timing
- Reset values: RegWrite=0, write_register=0, write_data=0, pending=0, rsv_err=0, prio=0.
- Grant latency: 0 cycles. a_gnt/b_gnt are combinational from req and prio.
- Write latency: RegWrite is asserted in the cycle after the grant. The register file captures the write on the following edge, 2 edges after the grant cycle begins.
- Pending clear: visible in the cycle after the grant. This is one cycle before the register file holds the value. The stall logic forwards write_data in that cycle.
- Back-to-back: one write per cycle sustained. With both requesting continuously, grants alternate A,B,A,B starting from prio.
- Reset asserted mid-transfer: an in-flight RegWrite drops immediately and prio returns to 0. Requesters must re-present their requests after reset deasserts.

## Configuration
- RF_ZERO_LOCK_EN defined:
  - A granted write to register 0 is still granted and handshaken, but RegWrite stays 0 for that write.
  - Reserve of register 0 is ignored, so pending[0] is held at 0 and rsv_err is never raised for register 0.
- RF_ZERO_LOCK_EN undefined: register 0 is an ordinary register.

## Test plan
- Reset then a_req=1, a_reg=3, a_data=16'h00AA, one cycle -> a_gnt=1 same cycle; next cycle RegWrite=1, write_register=3, write_data=16'h00AA; cycle after that, RegWrite=0.
- Both request continuously for 4 cycles with A regs 1,2 and B regs 5,6 -> grant order A,B,A,B; RegWrite writes regs 1,5,2,6 on consecutive cycles.
- rsv_valid with rsv_reg=7 -> pending=16'h0080; later b_req with b_reg=7 granted -> pending=16'h0000 the next cycle.
- Reserve 4, then reserve 4 again while pending -> rsv_err=1 and stays 1. Same-cycle reserve 9 and grant to reg 9 with pending[9]=1 -> pending[9] stays 1, rsv_err unchanged.
- With RF_ZERO_LOCK_EN, a_req with a_reg=0 -> a_gnt=1 and RegWrite stays 0; rsv_reg=0 leaves pending=0. Without the macro -> RegWrite=1 and write_register=0.
- Assert reset low while RegWrite=1 and prio=1 -> RegWrite=0, pending=0, prio=0 immediately, without waiting for a clock edge.
